// File: rtl/uart_tx_serializer.sv
// UART transmitter: frames a parallel word as start, LSB-first data, optional
// parity and stop bits, timed by an external 16x-oversampling baud tick.
module uart_tx_serializer #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int PARITY  = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  localparam int IW = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [5:0]        tick_q, tick_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DBIT-1:0]   shift_q, shift_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Odd parity inverts the XOR reduction so the frame carries an odd count of ones.
  function automatic logic parity_bit(input logic [DBIT-1:0] d);
    return (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // tx_d reflects the current state, so the line trails the state by one clk
  // uniformly; every bit keeps its full length and frames get one idle clk.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = 1'b1;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (tx_start) begin
          shift_d = din;
          tick_d  = '0;
          par_d   = parity_bit(din);
          state_d = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (s_tick) begin
          if (tick_q == 6'd15) begin
            tick_d  = '0;
            idx_d   = '0;
            state_d = DATA;
          end else begin
            tick_d = tick_q + 6'd1;
          end
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (s_tick) begin
          if (tick_q == 6'd15) begin
            tick_d  = '0;
            shift_d = shift_q >> 1;
            if (idx_q == IW'(DBIT - 1)) begin
              state_d = (PARITY != 0) ? PAR : STOP;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            tick_d = tick_q + 6'd1;
          end
        end
      end
      PAR: begin
        tx_d = par_q;
        if (s_tick) begin
          if (tick_q == 6'd15) begin
            tick_d  = '0;
            state_d = STOP;
          end else begin
            tick_d = tick_q + 6'd1;
          end
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (s_tick) begin
          if (tick_q == 6'(SB_TICK - 1)) begin
            tick_d  = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            tick_d = tick_q + 6'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  assign tx           = tx_q;
  assign tx_busy      = busy_q;
  assign tx_done_tick = done_q;

endmodule
